// File: rtl/vx_ifetch_queue_if.sv
// Handshake bundle between fetch, the per-warp instruction queue and decode.
// slave: queue side (takes in_*/out_ready/flush, drives in_ready/out_*/busy); master: the opposite side.
interface vx_ifetch_queue_if #(
   parameter int NUM_WARPS   = 4,
   parameter int NUM_THREADS = 4,
   parameter int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
);
   logic                   in_valid;
   logic [WID_W-1:0]       in_wid;
   logic [NUM_THREADS-1:0] in_tmask;
   logic [31:0]            in_pc;
   logic [31:0]            in_instr;
   logic                   in_ready;

   logic                   out_valid;
   logic [WID_W-1:0]       out_wid;
   logic [NUM_THREADS-1:0] out_tmask;
   logic [31:0]            out_pc;
   logic [31:0]            out_instr;
   logic                   out_ready;

   logic                   flush;
   logic [WID_W-1:0]       flush_wid;
   logic                   busy;

   modport slave (
      input  in_valid, in_wid, in_tmask, in_pc, in_instr,
      output in_ready,
      output out_valid, out_wid, out_tmask, out_pc, out_instr,
      input  out_ready,
      input  flush, flush_wid,
      output busy
   );

   modport master (
      output in_valid, in_wid, in_tmask, in_pc, in_instr,
      input  in_ready,
      input  out_valid, out_wid, out_tmask, out_pc, out_instr,
      output out_ready,
      output flush, flush_wid,
      input  busy
   );
endinterface

// File: rtl/vx_ifetch_queue.sv
// Per-warp instruction FIFOs between fetch and decode, round-robin drained one per cycle.
// Ports: clk, reset (sync, active-high), bus (slave: in_*, out_*, flush, busy). Option: IFETCH_QUEUE_BYPASS_EN.
module vx_ifetch_queue #(
   parameter int CORE_ID     = 0,
   parameter int NUM_WARPS   = 4,
   parameter int NUM_THREADS = 4,
   parameter int DEPTH       = 2,
   parameter int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   vx_ifetch_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [NUM_THREADS-1:0] tmask;
      logic [31:0]            pc;
      logic [31:0]            instr;
   } entry_t;

   // core index only matters to trace hooks
   if (CORE_ID < 0) begin : g_core_id_neg
   end

   entry_t           mem    [NUM_WARPS][DEPTH];
   logic [PTR_W-1:0] wr_ptr [NUM_WARPS];
   logic [PTR_W-1:0] rd_ptr [NUM_WARPS];
   logic [CNT_W-1:0] count  [NUM_WARPS];
   logic [WID_W-1:0] last_grant;

   logic [NUM_WARPS-1:0] nonempty;
   logic [NUM_WARPS-1:0] elig;
   logic [NUM_WARPS-1:0] push_w;
   logic [NUM_WARPS-1:0] pop_w;
   logic [NUM_WARPS-1:0] flush_w;
   logic [WID_W-1:0]     win;
   logic [WID_W-1:0]     cand;
   logic                 any_elig;
   logic                 in_flushed;
   logic                 byp;
   logic                 byp_take;
   logic                 push;
   logic                 pop;
   entry_t               in_ent;
   entry_t               head;

   assign in_ent     = '{tmask: bus.in_tmask, pc: bus.in_pc, instr: bus.in_instr};
   assign in_flushed = bus.flush && (bus.flush_wid == bus.in_wid);

   // ready looks only at stored occupancy: a full queue refuses even while popping
   assign bus.in_ready = (count[bus.in_wid] != CNT_W'(DEPTH));

   always_comb begin
      nonempty = '0;
      elig     = '0;
      flush_w  = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         flush_w[w]  = bus.flush && (bus.flush_wid == WID_W'(w));
         nonempty[w] = (count[w] != '0);
         elig[w]     = nonempty[w] && !flush_w[w];
      end
   end

   // scan starts just after the last granted warp and wraps
   always_comb begin
      win      = '0;
      cand     = '0;
      any_elig = 1'b0;
      for (int i = 1; i <= NUM_WARPS; i++) begin
         cand = WID_W'((int'(last_grant) + i) % NUM_WARPS);
         if (!any_elig && elig[cand]) begin
            any_elig = 1'b1;
            win      = cand;
         end
      end
   end

`ifdef IFETCH_QUEUE_BYPASS_EN
   // idle queue: hand the response straight to decode
   assign byp = bus.in_valid && bus.in_ready
             && (count[bus.in_wid] == '0)
             && !any_elig && !in_flushed;
`else
   assign byp = 1'b0;
`endif

   assign byp_take = byp && bus.out_ready;
   assign push     = bus.in_valid && bus.in_ready
                  && !in_flushed && !byp_take;
   assign pop      = any_elig && bus.out_ready;

   always_comb begin
      push_w = '0;
      pop_w  = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         push_w[w] = push && (bus.in_wid == WID_W'(w));
         pop_w[w]  = pop && (win == WID_W'(w));
      end
   end

   assign head = mem[win][rd_ptr[win]];

   always_comb begin
      bus.out_valid = any_elig || byp;
      bus.out_wid   = '0;
      bus.out_tmask = '0;
      bus.out_pc    = '0;
      bus.out_instr = '0;
      if (any_elig) begin
         bus.out_wid   = win;
         bus.out_tmask = head.tmask;
         bus.out_pc    = head.pc;
         bus.out_instr = head.instr;
      end else if (byp) begin
         bus.out_wid   = bus.in_wid;
         bus.out_tmask = bus.in_tmask;
         bus.out_pc    = bus.in_pc;
         bus.out_instr = bus.in_instr;
      end
   end

   assign bus.busy = |nonempty;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            count[w]  <= '0;
            wr_ptr[w] <= '0;
            rd_ptr[w] <= '0;
         end
         last_grant <= WID_W'(NUM_WARPS - 1);
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (flush_w[w]) begin
               count[w]  <= '0;
               wr_ptr[w] <= '0;
               rd_ptr[w] <= '0;
            end else begin
               if (push_w[w])
                  wr_ptr[w] <= wr_ptr[w] + PTR_W'(1);
               if (pop_w[w])
                  rd_ptr[w] <= rd_ptr[w] + PTR_W'(1);
               if (push_w[w] && !pop_w[w])
                  count[w] <= count[w] + CNT_W'(1);
               else if (!push_w[w] && pop_w[w])
                  count[w] <= count[w] - CNT_W'(1);
            end
         end
         if (pop)
            last_grant <= win;
         else if (byp_take)
            last_grant <= bus.in_wid;
      end
   end

   // storage needs no reset: count gates every read
   always_ff @(posedge clk) begin
      if (push)
         mem[bus.in_wid][wr_ptr[bus.in_wid]] <= in_ent;
   end
endmodule
